// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch bridge: SRAM-like req/addr_ok/data_ok fetch port to single-beat AXI reads.
// One AR in flight at a time, up to MAX_OUTST accepted fetches awaiting R, strictly in order.
module inst_axi_rd_bridge #(
  parameter logic [3:0] ARID      = 4'd0,
  parameter int         MAX_OUTST = 2,
  parameter bit         MAP_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_bus_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  // Handshakes: AR transfers when arvalid && arready; R transfers when rvalid && rready.
  // arvalid/araddr never change while arvalid is high and arready is low.

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTST);

  typedef enum logic {AR_IDLE = 1'b0, AR_BUSY = 1'b1} ar_state_t;

  ar_state_t   state, state_nxt;
  logic [1:0]  cnt;
  logic [1:0]  size_q;
  logic        accept;
  logic        r_done;
  logic [31:0] phys_addr;
  logic        unused_ok;

  assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid};

  // kseg0/kseg1 both fold onto the low 512 MB of physical space.
  always_comb begin
    phys_addr = inst_sram_addr;
    if (MAP_EN && (inst_sram_addr[31:30] == 2'b10)) begin
      phys_addr = {3'b000, inst_sram_addr[28:0]};
    end
  end

  // Slot release is not forwarded into acceptance, keeping rvalid off the addr_ok path.
  assign accept = inst_sram_req && (state == AR_IDLE) && (cnt < MAX_CNT);
  assign rready = (cnt != 2'd0);
  assign r_done = rvalid && rready && rlast;

  assign inst_sram_addr_ok = accept;
  assign inst_sram_data_ok = r_done;
  assign inst_sram_rdata   = rdata;
  assign inst_bus_err      = r_done && (rresp != 2'b00);

  assign arid    = ARID;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state == AR_BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= AR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == AR_IDLE) begin
      if (accept) state_nxt = AR_BUSY;
    end else begin
      if (arready) state_nxt = AR_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      araddr <= 32'd0;
      size_q <= 2'd0;
    end else if (accept) begin
      araddr <= phys_addr;
      size_q <= inst_sram_size;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 2'd0;
    end else begin
      case ({accept, r_done})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: doc/inst_axi_rd_bridge.md
Name: inst_axi_rd_bridge

Overview:
- Sits directly on the instruction side of the IF stage, between it and the AXI bus of the SoC.
- Accepts the IF stage's SRAM-like fetch requests (req/addr_ok/data_ok handshake) and translates kseg0/kseg1 virtual addresses to physical.
- Issues single-beat AXI read bursts and returns every accepted request's data in order.
- Read-only: fetch never writes, so no AXI write channels exist.

Parameters:
ARID, 4'd0, constant AXI ID driven on arid.
MAX_OUTST, 2, maximum accepted-but-not-returned requests (1..3).
MAP_EN, 1, 1 enables fixed kseg0/kseg1 to physical mapping; 0 passes the address through unchanged.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_sram_req  in  1  fetch request from IF stage
inst_sram_wr  in  1  write flag; always 0 from IF; ignored
inst_sram_size  in  2  transfer size; 2 = word; drives arsize
inst_sram_wstrb  in  4  ignored
inst_sram_addr  in  32  fetch virtual address
inst_sram_wdata  in  32  ignored
inst_sram_addr_ok  out  1  request accepted this cycle
inst_sram_data_ok  out  1  instruction word valid this cycle
inst_sram_rdata  out  32  instruction word
inst_bus_err  out  1  1-cycle pulse with data_ok when rresp != 0
arid  out  4  = ARID
araddr  out  32  physical fetch address
arlen  out  8  constant 0
arsize  out  3  {1'b0, latched size}
arburst  out  2  constant 2'b01
arlock  out  2  constant 0
arcache  out  4  constant 0
arprot  out  3  constant 0
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  ignored; single ID, in-order
rdata  in  32  read data
rresp  in  2  read response
rlast  in  1  last beat
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Reset (synchronous): state AR_IDLE, arvalid=0, araddr=0, arsize=0, outstanding count cnt=0. Consequently addr_ok=0, data_ok=0, rready=0, inst_bus_err=0.
- AR FSM has two states, AR_IDLE and AR_BUSY.
- Acceptance rule:
  - addr_ok = req && state==AR_IDLE && cnt<MAX_OUTST, combinational.
  - Completions in the same cycle do not free a slot; there is no bypass.
- On acceptance in cycle T:
  - araddr and arsize are latched.
  - State goes to AR_BUSY; arvalid=1 from T+1.
- AR_BUSY: araddr and arvalid stay stable until arvalid && arready. On that cycle the state returns to AR_IDLE and arvalid=0 next cycle. The earliest next acceptance is the cycle after the handshake.
- Address mapping when MAP_EN=1:
  - Addresses 0x8000_0000-0xBFFF_FFFF map to {3'b000, addr[28:0]}.
  - All other addresses pass through unchanged.
- Counter rules:
  - cnt increments on acceptance.
  - cnt decrements on rvalid && rready && rlast.
  - Both in one cycle leave cnt unchanged.
  - cnt never exceeds MAX_OUTST and never underflows.
- R channel:
  - rready = (cnt != 0).
  - data_ok = rvalid && rready && rlast.
  - inst_sram_rdata = rdata, combinational; rdata must not be registered.
  - inst_bus_err = data_ok && (rresp != 0).
  - A response with rresp != 0 still produces data_ok.
  - rvalid while cnt==0 is not acknowledged and produces no data_ok.
- Ordering: responses return in acceptance order. The bridge never drops, reorders, or cancels an accepted request. Exception/eret flush is handled by the IF stage's cancel logic, which discards the corresponding data_ok.
- Minimum latency: req in cycle T → arvalid in T+1 → arready in T+1 → rvalid in T+2 → data_ok in T+2.
- Reset mid-transaction clears all state. Any in-flight AXI beat is not acknowledged, because rready=0 after reset. The system resets the bus in the same cycle.
- All outputs come from registers or from combinational logic of registers and inputs. There is no combinational path from rvalid to addr_ok.

Test Plan:
- Single fetch: req=1, addr=0xBFC0_0000, arready=1; slave returns rdata=0x3C08_BFC0 two cycles later → addr_ok at T, araddr=0x1FC0_0000 and arvalid in T+1 only, data_ok and rdata=0x3C08_BFC0 in T+2, cnt back to 0.
- AR backpressure: arready low for 3 cycles → arvalid and araddr held stable through all 3 cycles; addr_ok stays 0 throughout despite req=1; handshake on the 4th cycle.
- Outstanding limit (MAX_OUTST=2): two requests at 0x8000_0000 and 0x8000_0004 accepted while rvalid is held off → third req sees addr_ok=0 until the first data_ok; responses 0x11111111 then 0x22222222 return in that order.
- Simultaneous accept and complete with cnt=1: addr_ok and rvalid&&rlast in the same cycle → cnt stays 1.
- Error and stray beat: rresp=2'b10 → data_ok=1 and inst_bus_err=1 for one cycle; rvalid=1 with cnt=0 → rready=0, data_ok=0.
- Reset mid-flight: assert reset while arvalid=1 and cnt=1 → next cycle arvalid=0, cnt=0, rready=0; the subsequent fetch at 0x0000_1000 (MAP_EN=1) gives araddr=0x0000_1000.
